// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
// Shared constants for the immediate extender and the decode stage:
//   MODE_*  : 2-bit extension mode select (decode drives these onto `mode`)
//   ST_*    : 2-bit occupancy state of the extender's output buffer
package imm_ext_pkg;

    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_SIGN   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
// Purely combinational immediate extender, shared with the single-cycle
// datapath.
//   imm    [IN_W-1:0]  raw immediate field
//   mode   [1:0]       MODE_ZERO / MODE_SIGN / MODE_UPPER / MODE_BRANCH
//   result [OUT_W-1:0] extended immediate
// IN_W must satisfy 1 <= IN_W <= OUT_W-2.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;

    assign zero_ext = {{PAD_W{1'b0}}, imm};
    assign sign_ext = {{PAD_W{imm[IN_W-1]}}, imm};

    always_comb begin
        result = zero_ext;
        case (mode)
            MODE_ZERO:   result = zero_ext;
            MODE_SIGN:   result = sign_ext;
            MODE_UPPER:  result = {imm, {PAD_W{1'b0}}};
            // The two dropped MSBs are sign copies because PAD_W >= 2.
            MODE_BRANCH: result = {sign_ext[OUT_W-3:0], 2'b00};
            default:     result = zero_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Immediate extender with a registered valid/ready output stage backed by a
// 2-entry skid buffer (main + skid), giving full throughput without a
// combinational ready path.
//   clk, reset           clock, asynchronous active-high reset
//   in_valid / in_ready  upstream handshake (in_ready from state only)
//   imm [IN_W-1:0], mode input immediate and extension mode
//   out_valid/out_ready  downstream handshake
//   ext_imm [OUT_W-1:0]  extended immediate (main register)
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | nothing buffered, out_valid=0
// ST_ONE   | main holds a result, skid unused
// ST_FULL  | main and skid both hold results, in_ready=0
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext_imm
);

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [OUT_W-1:0] ext_result;
    logic             in_fire;
    logic             out_fire;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm    (imm),
        .mode   (mode),
        .result (ext_result)
    );

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign ext_imm   = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = ext_result;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = ext_result;
                end else if (in_fire) begin
                    skid_d  = ext_result;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_imm;
    logic [1:0]  a_mode;
    logic [31:0] a_ext;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_imm;
    logic [1:0]  b_mode;
    logic [11:0] b_ext;

    int total = 0;
    int bad   = 0;

    logic [31:0] a_sb[$];
    logic [31:0] b_sb[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .imm       (a_imm),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .ext_imm   (a_ext)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(12)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .imm       (b_imm),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .ext_imm   (b_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference extension built from arithmetic masks rather than concatenation.
    function automatic logic [31:0] model(input logic [31:0] imm_in, input logic [1:0] md,
                                          input int in_w, input int out_w);
        logic [31:0] m_in, m_out, v, s;
        m_in  = (32'd1 << in_w) - 32'd1;
        m_out = (out_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << out_w) - 32'd1);
        v     = imm_in & m_in;
        s     = (((v >> (in_w - 1)) & 32'd1) != 0) ? ((v | ~m_in) & m_out) : v;
        case (md)
            2'd0:    model = v;
            2'd1:    model = s;
            2'd2:    model = (v << (out_w - in_w)) & m_out;
            default: model = (s << 2) & m_out;
        endcase
    endfunction

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'h7066, 2'd0, 32'h0000_7066};
        vecs[1]  = '{16'h0000, 2'd1, 32'h0000_0000};
        vecs[2]  = '{16'hFFEF, 2'd0, 32'h0000_FFEF};
        vecs[3]  = '{16'hFFEF, 2'd1, 32'hFFFF_FFEF};
        vecs[4]  = '{16'h1234, 2'd2, 32'h1234_0000};
        vecs[5]  = '{16'hFFFF, 2'd3, 32'hFFFF_FFFC};
        vecs[6]  = '{16'h0004, 2'd3, 32'h0000_0010};
        vecs[7]  = '{16'h7FFF, 2'd1, 32'h0000_7FFF};
        vecs[8]  = '{16'hFFFF, 2'd2, 32'hFFFF_0000};
        vecs[9]  = '{16'h8000, 2'd0, 32'h0000_8000};
        vecs[10] = '{16'h8000, 2'd3, 32'hFFFE_0000};

        reset = 1'b1;
        a_in_valid = 0; a_imm = '0; a_mode = 2'd0; a_out_ready = 1'b1;
        b_in_valid = 0; b_imm = '0; b_mode = 2'd0; b_out_ready = 1'b0;
        #2;
        check("reset out_valid", {31'd0, a_out_valid}, 32'd0);
        check("reset in_ready", {31'd0, a_in_ready}, 32'd1);
        check("reset ext_imm", a_ext, 32'd0);
        #10;
        reset = 1'b0;
        tick();

        // Streaming table, out_ready=1: each result appears one edge after input.
        for (int i = 0; i < 11; i++) begin
            a_in_valid = 1'b1;
            a_imm  = vecs[i].imm;
            a_mode = vecs[i].mode;
            check($sformatf("vec%0d in_ready", i), {31'd0, a_in_ready}, 32'd1);
            tick();
            check($sformatf("vec%0d out_valid", i), {31'd0, a_out_valid}, 32'd1);
            check($sformatf("vec%0d ext_imm", i), a_ext, vecs[i].exp);
        end
        a_in_valid = 1'b0;
        tick();
        check("drain out_valid", {31'd0, a_out_valid}, 32'd0);

        // Back-pressure: A,B accepted, then held C changes are ignored while full.
        a_out_ready = 1'b0;
        a_mode = 2'd0;
        a_in_valid = 1'b1; a_imm = 16'h0001;
        tick();
        check("bp A ext", a_ext, 32'h1);
        check("bp in_ready after 1", {31'd0, a_in_ready}, 32'd1);
        a_imm = 16'h0002;
        tick();
        check("bp in_ready after 2", {31'd0, a_in_ready}, 32'd0);
        check("bp ext hold A", a_ext, 32'h1);
        a_imm = 16'h00C0;
        tick();
        check("bp stall1 ext", a_ext, 32'h1);
        check("bp stall1 in_ready", {31'd0, a_in_ready}, 32'd0);
        a_imm = 16'h00C1;
        tick();
        check("bp stall2 ext", a_ext, 32'h1);
        a_imm = 16'h0003;
        a_out_ready = 1'b1;
        tick();
        check("bp out B", a_ext, 32'h2);
        check("bp in_ready back", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("bp out C", a_ext, 32'h3);
        a_imm = 16'h0004;
        tick();
        check("bp out D", a_ext, 32'h4);
        a_in_valid = 1'b0;
        tick();
        check("bp drained", {31'd0, a_out_valid}, 32'd0);

        // Async reset while FULL, asserted and released between edges.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_imm = 16'h0055; a_mode = 2'd1;
        tick();
        a_imm = 16'h0066;
        tick();
        a_in_valid = 1'b0;
        check("pre-reset full", {31'd0, a_in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async rst out_valid", {31'd0, a_out_valid}, 32'd0);
        check("async rst in_ready", {31'd0, a_in_ready}, 32'd1);
        check("async rst ext_imm", a_ext, 32'd0);
        #4;
        reset = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post-rst idle%0d", i), {31'd0, a_out_valid}, 32'd0);
        end
        a_in_valid = 1'b1; a_imm = 16'h00AB; a_mode = 2'd2;
        tick();
        a_in_valid = 1'b0;
        check("post-rst new ext", a_ext, 32'h00AB_0000);
        check("post-rst new valid", {31'd0, a_out_valid}, 32'd1);
        tick();

        // Random traffic on both configurations against scoreboards.
        fork
            begin : rand_a
                int got_n;
                bit stalled;
                logic [31:0] held;
                got_n = 0; stalled = 0; held = '0;
                a_in_valid = 0;
                for (int c = 0; c < 40000 && got_n < 10000; c++) begin
                    if (stalled) begin
                        check("A stall valid", {31'd0, a_out_valid}, 32'd1);
                        check("A stall hold", a_ext, held);
                    end
                    if (!(a_in_valid && !a_in_ready)) begin
                        a_in_valid = ($urandom_range(3) != 0);
                        a_imm  = 16'($urandom);
                        a_mode = 2'($urandom);
                    end
                    a_out_ready = ($urandom_range(3) != 0);
                    if (a_out_valid && a_out_ready) begin
                        if (a_sb.size() == 0) check("A spurious out", a_ext, 32'hDEAD_BEEF);
                        else check("A rand data", a_ext, a_sb.pop_front());
                        got_n++;
                    end
                    if (a_in_valid && a_in_ready)
                        a_sb.push_back(model({16'd0, a_imm}, a_mode, 16, 32));
                    stalled = a_out_valid && !a_out_ready;
                    held = a_ext;
                    tick();
                end
                check("A transfer count reached", {31'd0, got_n >= 10000}, 32'd1);
                a_in_valid = 0;
            end
            begin : rand_b
                int got_n;
                bit stalled;
                logic [31:0] held;
                got_n = 0; stalled = 0; held = '0;
                b_in_valid = 0;
                for (int c = 0; c < 40000 && got_n < 10000; c++) begin
                    if (stalled) begin
                        check("B stall valid", {31'd0, b_out_valid}, 32'd1);
                        check("B stall hold", {20'd0, b_ext}, held);
                    end
                    if (!(b_in_valid && !b_in_ready)) begin
                        b_in_valid = ($urandom_range(3) != 0);
                        b_imm  = 8'($urandom);
                        b_mode = 2'($urandom);
                    end
                    b_out_ready = ($urandom_range(3) != 0);
                    if (b_out_valid && b_out_ready) begin
                        if (b_sb.size() == 0) check("B spurious out", {20'd0, b_ext}, 32'hDEAD_BEEF);
                        else check("B rand data", {20'd0, b_ext}, b_sb.pop_front());
                        got_n++;
                    end
                    if (b_in_valid && b_in_ready)
                        b_sb.push_back(model({24'd0, b_imm}, b_mode, 8, 12));
                    stalled = b_out_valid && !b_out_ready;
                    held = {20'd0, b_ext};
                    tick();
                end
                check("B transfer count reached", {31'd0, got_n >= 10000}, 32'd1);
                b_in_valid = 0;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, mode-selectable immediate extender with a registered valid/ready output stage, the successor to the fixed 16→32 zero-extender used by the single-cycle MIPS datapath. It widens an IN_W-bit immediate to OUT_W bits by zero-extension, sign-extension, upper placement (LUI) or sign-extension with a ×4 shift (branch offset). It sits between decode and the ID/EX boundary of the pipelined core. A 2-entry skid buffer gives full throughput under back-pressure without a combinational ready path.

## Interface
- IN_W, 16, immediate input width; legal range 1 ≤ IN_W ≤ OUT_W−2
- OUT_W, 32, extended output width
- clk  input  1  rising-edge clock; the block uses one clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  imm/mode are valid this cycle
- in_ready  output  1  block can accept; decoded from registered state only
- imm  input  IN_W  raw immediate field
- mode  input  2  0=ZERO, 1=SIGN, 2=UPPER, 3=BRANCH
- out_valid  output  1  ext_imm holds a result
- out_ready  input  1  consumer accepts this cycle
- ext_imm  output  OUT_W  extended immediate

## Operation
- Input transfer ("in fire") = in_valid & in_ready; output transfer ("out fire") = out_valid & out_ready.
- Extension is computed combinationally from imm/mode at the input and the result is stored; mode is not stored.
  - ZERO: {(OUT_W−IN_W){0}, imm}.
  - SIGN: {(OUT_W−IN_W){imm[IN_W−1]}, imm}.
  - UPPER: imm placed in bits [OUT_W−1 : OUT_W−IN_W], lower bits 0.
  - BRANCH: SIGN result shifted left by 2, bits [1:0]=0. The top 2 bits of the SIGN result are discarded; the parameter constraint guarantees they are sign copies.
- Storage: main register (drives ext_imm) and skid register.
- State machine states: EMPTY, ONE, FULL.
  - EMPTY: in fire → main←result, go to ONE.
  - ONE, in fire and out fire → main←result, stay in ONE.
  - ONE, in fire without out fire → skid←result, go to FULL.
  - ONE, out fire without in fire → go to EMPTY.
  - FULL: no input accepted. Out fire → main←skid, go to ONE.
- out_valid = (state ≠ EMPTY); in_ready = (state ≠ FULL).
- Data is never dropped or duplicated, and output order equals input order.
- ext_imm holds its value while out_valid & !out_ready.
- ext_imm is don't-care when out_valid=0. The implementation leaves the main register unchanged in that case.

## Timing
- Reset (asynchronous) forces the following immediately, independent of clk:
  - state=EMPTY
  - out_valid=0
  - in_ready=1
  - ext_imm=0
  - skid register=0
- After reset is released, the first in fire can occur on the first rising clk edge.
- Latency: the result from an in fire at edge N is visible on ext_imm with out_valid=1 after edge N.
- Throughput: 1 result per cycle while out_ready=1.
- in_ready drops one cycle after the first stalled acceptance, that is, after the transition into FULL. Both entries are then occupied.
- In FULL with out_ready=1, in_ready returns to 1 after the edge. Back-to-back input resumes with no bubble on the output.
- Simultaneous in fire and out fire in ONE replaces main in the same edge; the old value is consumed.
- Reset asserted mid-stream discards all buffered data; no stale out_valid pulse is allowed after release.
- in_valid asserted while in_ready=0 is ignored. The upstream stage must hold imm/mode; no capture occurs.

## Structure
- Shared package imm_ext_pkg:
  - mode constants MODE_ZERO/SIGN/UPPER/BRANCH (2-bit);
  - state encoding ST_EMPTY/ST_ONE/ST_FULL (2-bit).
- The decode stage uses the same mode constants.
- Sub-module imm_ext_core: purely combinational (imm, mode) → OUT_W result, parametrised by IN_W/OUT_W. It is reused by the single-cycle datapath in place of the fixed extender.
- The top level contains the state register, main/skid registers and the handshake decode only.

## Test plan
- Reset then ZERO imm=0x7066, SIGN imm=0x0000, ZERO imm=0xFFEF with out_ready=1 → ext_imm 0x00007066, 0x00000000, 0x0000FFEF on consecutive cycles, each one cycle after input.
- SIGN 0xFFEF → 0xFFFFFFEF; UPPER 0x1234 → 0x12340000; BRANCH 0xFFFF → 0xFFFFFFFC; BRANCH 0x0004 → 0x00000010.
- Back-pressure: stream 4 inputs with out_ready=0 from cycle 1.
  - in_ready=0 after 2 acceptances.
  - Raise out_ready → outputs appear in order, 1 per cycle, with no loss.
- Random in_valid/out_ready (≥10k transfers, IN_W=16/OUT_W=32 and IN_W=8/OUT_W=12) against a scoreboard → every result matches the model, in order, and ext_imm is stable while stalled.
- Assert reset asynchronously between clock edges while in FULL:
  - out_valid=0, in_ready=1, ext_imm=0 immediately;
  - no output until new input after release.
- in_valid held with in_ready=0 and changing imm → the changed imm is not captured; the accepted sequence equals only the fired transfers.
